// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// A multiply or divide runs one radix-2 step per clock on operand magnitudes.
// The sign correction is applied once, in FINISH, before the result is written.
// MTHI and MTLO load a result register directly in one cycle and never raise busy.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO are handled here in one edge
// CALC   | WIDTH iterations of shift-add or restoring shift-subtract
// FINISH | sign fix-up, divide-by-zero override, write hi/lo, pulse done
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               b_zero_q, b_zero_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   lowr_q, lowr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  // Operand magnitudes at the accepting edge (signed ops only take |x|)
  logic               op_signed;
  logic               in1_neg, in2_neg;
  logic [WIDTH-1:0]   in1_mag, in2_mag;

  // One iteration of each algorithm
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  // Signed fix-up values
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_neg;
  logic [WIDTH-1:0]   rem_neg;
  logic [WIDTH-1:0]   opa_neg;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign in1_neg   = op_signed && in1[WIDTH-1];
  assign in2_neg   = op_signed && in2[WIDTH-1];
  assign in1_mag   = in1_neg ? -in1 : in1;
  assign in2_mag   = in2_neg ? -in2 : in2;

  // Shift-add: the multiplier sits in lowr_q and is consumed LSB first while
  // the partial product enters from the top of acc_q.
  assign mul_sum   = {1'b0, acc_q} + (lowr_q[0] ? {1'b0, opa_q} : '0);

  // Restoring divide: the partial remainder is always below the divisor, so
  // the shifted value fits in WIDTH+1 bits and the top bit of the
  // difference is a clean borrow.
  assign div_shift = {acc_q, lowr_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};

  assign prod      = {acc_q, lowr_q};
  assign prod_neg  = -prod;
  assign quo_neg   = -lowr_q;
  assign rem_neg   = -acc_q;
  assign opa_neg   = -opa_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      lowr_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      b_zero_q <= b_zero_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      lowr_q   <= lowr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  // Next-state, iteration step and result write
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    b_zero_d = b_zero_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    lowr_d   = lowr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d  = S_CALC;
              cnt_d    = CNT_W'(WIDTH - 1);
              is_div_d = op[1];
              neg_a_d  = in1_neg;
              neg_b_d  = in2_neg;
              b_zero_d = (in2 == '0);
              opa_d    = in1_mag;
              opb_d    = in2_mag;
              acc_d    = '0;
              // Multiplier for a multiply, dividend for a divide
              lowr_d   = op[1] ? in1_mag : in2_mag;
            end
            OP_MTHI: hi_d = in1;
            OP_MTLO: lo_d = in1;
            default: ;
          endcase
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_d  = div_diff[WIDTH-1:0];
            lowr_d = {lowr_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d  = div_shift[WIDTH-1:0];
            lowr_d = {lowr_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d  = mul_sum[WIDTH:1];
          lowr_d = {mul_sum[0], lowr_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (b_zero_q) begin
            // Hand the dividend back unchanged in hi
            lo_d = '1;
            hi_d = neg_a_q ? opa_neg : opa_q;
            dz_d = 1'b1;
          end else begin
            // Most-negative / -1 wraps back to most-negative here, rem 0
            lo_d = (neg_a_q ^ neg_b_q) ? quo_neg : lowr_q;
            hi_d = neg_a_q ? rem_neg : acc_q;
          end
        end else begin
          {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : prod;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, a randomized run
// against a plain-arithmetic reference, and a WIDTH=8 instance.
module tb_muldiv_unit;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b0;
  logic [31:0] in1 = '0, in2 = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [2:0]  op8 = 3'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .in1(a8), .in2(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
  );

  // Reference: results from ordinary integer arithmetic
  task automatic ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    ez = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      MULT: begin
        sp = longint'(sa) * longint'(sb);
        {eh, el} = sp;
      end
      MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {eh, el} = up;
      end
      DIV: begin
        if (b == 0) begin
          el = 32'hffffffff; eh = a; ez = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hffffffff) begin
          el = 32'h80000000; eh = 32'h0;
        end else begin
          el = sa / sb;
          eh = sa % sb;
        end
      end
      default: begin
        if (b == 0) begin
          el = 32'hffffffff; eh = a; ez = 1'b1;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
    endcase
  endtask

  // Issue one op from a post-edge point; returns in the cycle busy has dropped
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int ncyc, output logic d, output logic [31:0] h,
                       output logic [31:0] l, output logic z);
    start = 1'b1; op = o; in1 = a; in2 = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); in1 = $urandom; in2 = $urandom;
    ncyc = 0;
    while (busy === 1'b1 && ncyc < 100) begin
      ncyc++;
      @(posedge clk); #1;
    end
    d = done; h = hi; l = lo; z = div_zero;
  endtask

  task automatic do_op8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int ncyc, output logic d, output logic [7:0] h,
                        output logic [7:0] l, output logic z);
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    ncyc = 0;
    while (busy8 === 1'b1 && ncyc < 100) begin
      ncyc++;
      @(posedge clk); #1;
    end
    d = done8; h = hi8; l = lo8; z = dz8;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op = MTHI; in1 = 32'hdeadbeef;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    total++; if ({busy, done, div_zero} !== 3'b000) begin bad++; $display("FAIL reset_flags: busy/done/dz got %b want 000", {busy, done, div_zero}); end
    total++; if ({busy8, done8, dz8, hi8, lo8} !== 19'h0) begin bad++; $display("FAIL reset_w8: got %h want 0", {busy8, done8, dz8, hi8, lo8}); end
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [2:0]  vo [5] = '{MULTU, MULT, DIV, DIVU, DIV};
    logic [31:0] va [5] = '{32'hffffffff, 32'hffffffff, 32'hfffffff9, 32'h00000005, 32'h80000000};
    logic [31:0] vb [5] = '{32'h0000000f, 32'h00000002, 32'h00000002, 32'h00000000, 32'hffffffff};
    logic [31:0] eh [5] = '{32'h0000000e, 32'hffffffff, 32'hffffffff, 32'h00000005, 32'h00000000};
    logic [31:0] el [5] = '{32'hfffffff1, 32'hfffffffe, 32'hfffffffd, 32'hffffffff, 32'h80000000};
    logic        ez [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int n; logic d, z; logic [31:0] h, l;
    for (int i = 0; i < 5; i++) begin
      do_op(vo[i], va[i], vb[i], n, d, h, l, z);
      total++; if (n !== 33) begin bad++; $display("FAIL dir%0d_busy_cycles: got %0d want 33", i, n); end
      total++; if (d !== 1'b1) begin bad++; $display("FAIL dir%0d_done: got %b want 1", i, d); end
      total++; if (h !== eh[i]) begin bad++; $display("FAIL dir%0d_hi: got %h want %h", i, h, eh[i]); end
      total++; if (l !== el[i]) begin bad++; $display("FAIL dir%0d_lo: got %h want %h", i, l, el[i]); end
      total++; if (z !== ez[i]) begin bad++; $display("FAIL dir%0d_div_zero: got %b want %b", i, z, ez[i]); end
    end
    @(posedge clk); #1;
    total++; if ({done, div_zero} !== 2'b00) begin bad++; $display("FAIL done_pulse_width: done/dz got %b want 00", {done, div_zero}); end
  endtask

  task automatic test_move();
    start = 1'b1; op = MTHI; in1 = 32'h12345678;
    @(posedge clk); #1;
    total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL mthi_flags: busy/done got %b want 00", {busy, done}); end
    op = MTLO; in1 = 32'h9abcdef0;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (lo !== 32'h9abcdef0) begin bad++; $display("FAIL mtlo_lo: got %h want 9abcdef0", lo); end
    total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mtlo_hi_kept: got %h want 12345678", hi); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL mtlo_flags: busy/done got %b want 00", {busy, done}); end
  endtask

  task automatic test_reserved();
    start = 1'b1; op = 3'b110; in1 = 32'hffff0000; in2 = 32'h1;
    @(posedge clk); #1;
    op = 3'b111;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if ({hi, lo} !== {32'h12345678, 32'h9abcdef0}) begin bad++; $display("FAIL reserved_regs: got %h %h want 12345678 9abcdef0", hi, lo); end
    total++; if ({busy, done, div_zero} !== 3'b000) begin bad++; $display("FAIL reserved_flags: got %b want 000", {busy, done, div_zero}); end
  endtask

  task automatic test_ignore();
    logic [31:0] eh, el; logic ez; int n; bit seen;
    ref_model(MULTU, 32'h12345678, 32'h9abcdef1, eh, el, ez);
    start = 1'b1; op = MULTU; in1 = 32'h12345678; in2 = 32'h9abcdef1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; op = MTLO; in1 = 32'h0000aaaa;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(posedge clk); #1; end
    total++; if (n >= 100) begin bad++; $display("FAIL ignore_timeout: busy still high after %0d cycles", n); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ignore_done: got %b want 1", done); end
    total++; if ({hi, lo} !== {eh, el}) begin bad++; $display("FAIL ignore_result: got %h %h want %h %h", hi, lo, eh, el); end
    @(posedge clk); #1;
    start = 1'b1; op = DIVU; in1 = 32'h00001234; in2 = 32'h00000007;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abort_flags: busy/done got %b want 00", {busy, done}); end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL abort_regs: got %h %h want 0 0", hi, lo); end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got activity=%b want 0", seen); end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hffffffff;
      3: return 32'h80000000;
      4: return 32'h7fffffff;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0] o; logic [31:0] a, b, eh, el, h, l; logic ez, d, z; int n;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      a = pick();
      b = pick();
      ref_model(o, a, b, eh, el, ez);
      do_op(o, a, b, n, d, h, l, z);
      total++;
      if (n !== 33 || d !== 1'b1 || h !== eh || l !== el || z !== ez) begin
        bad++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: got cyc=%0d done=%b hi=%h lo=%h dz=%b want cyc=33 done=1 hi=%h lo=%h dz=%b",
                 i, o, a, b, n, d, h, l, z, eh, el, ez);
      end
    end
  endtask

  task automatic test_width8();
    logic [2:0] o; logic [7:0] a, b, eh, el, h, l; logic ez, d, z; int n;
    int sa, sb, p;
    do_op8(MULT, 8'h80, 8'h80, n, d, h, l, z);
    total++; if (n !== 9) begin bad++; $display("FAIL w8_busy_cycles: got %0d want 9", n); end
    total++; if ({d, h, l, z} !== {1'b1, 8'h40, 8'h00, 1'b0}) begin bad++; $display("FAIL w8_mult: done/hi/lo/dz got %b %h %h %b want 1 40 00 0", d, h, l, z); end
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(0, 3));
      a = 8'($urandom);
      b = (i % 4 == 3) ? 8'h00 : 8'($urandom);
      sa = int'($signed(a));
      sb = int'($signed(b));
      ez = 1'b0;
      case (o)
        MULT:  begin p = sa * sb; {eh, el} = 16'(p); end
        MULTU: begin p = int'(a) * int'(b); {eh, el} = 16'(p); end
        DIV: begin
          if (b == 0) begin el = 8'hff; eh = a; ez = 1'b1; end
          else if (a == 8'h80 && b == 8'hff) begin el = 8'h80; eh = 8'h00; end
          else begin el = 8'(sa / sb); eh = 8'(sa % sb); end
        end
        default: begin
          if (b == 0) begin el = 8'hff; eh = a; ez = 1'b1; end
          else begin el = a / b; eh = a % b; end
        end
      endcase
      do_op8(o, a, b, n, d, h, l, z);
      total++;
      if (n !== 9 || d !== 1'b1 || h !== eh || l !== el || z !== ez) begin
        bad++;
        $display("FAIL w8_rand%0d op=%0d a=%h b=%h: got cyc=%0d done=%b hi=%h lo=%h dz=%b want cyc=9 done=1 hi=%h lo=%h dz=%b",
                 i, o, a, b, n, d, h, l, z, eh, el, ez);
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_move();
    test_reserved();
    test_ignore();
    test_random();
    test_width8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; legal values are even integers of 4 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to accept op, in1 and in2 this cycle.
REQ-005 The block SHALL have port op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
REQ-006 The block SHALL have ports in1 and in2, input, WIDTH bits each: operand A (dividend or multiplicand) and operand B (divisor or multiplier).
REQ-007 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a MULT/MULTU/DIV/DIVU result is written.
REQ-009 The block SHALL have ports hi and lo, output, WIDTH bits each: the registered HI and LO result registers.
REQ-010 The block SHALL have port div_zero, output, 1 bit: flag that is valid together with done and marks a divide by zero.

Function
REQ-011 The block SHALL implement a three-state machine: IDLE, CALC and FINISH.
REQ-012 The block SHALL accept start only in IDLE; start in CALC or FINISH SHALL be ignored, including any MTHI or MTLO.
REQ-013 An accepted MTHI SHALL load hi with in1 at the accepting edge, leave lo unchanged, keep busy at 0 and leave done unasserted.
REQ-014 An accepted MTLO SHALL behave as MTHI but load lo instead of hi.
REQ-015 A reserved op with start SHALL be a no-op: no state change and no done.
REQ-016 An accepted MULT/MULTU/DIV/DIVU SHALL latch the operands and op, and move to CALC with iteration counter set to WIDTH-1.
REQ-017 CALC SHALL perform one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide) on operand magnitudes, and move to FINISH when the counter reaches 0, for exactly WIDTH cycles in CALC.
REQ-018 FINISH SHALL last one cycle, apply the sign correction, write hi/lo and done at its exit edge, and return to IDLE.
REQ-019 busy SHALL be 1 in CALC and FINISH, for exactly WIDTH+1 cycles after the accepting edge, and 0 otherwise.
REQ-020 done SHALL be 1 for exactly the one cycle following FINISH, with hi and lo already holding the new result in that cycle.
REQ-021 A new start SHALL be accepted in the same cycle that done is 1.
REQ-022 MULT SHALL treat operands as two's complement and MULTU as unsigned; both SHALL place the full 2*WIDTH-bit product as {hi, lo}.
REQ-023 DIV/DIVU SHALL place the quotient in lo and the remainder in hi.
REQ-024 Signed DIV SHALL truncate the quotient toward zero, and the remainder sign SHALL equal the dividend sign.
REQ-025 Signed DIV of the most negative value by -1 SHALL give lo = most negative value and hi = 0.
REQ-026 Divide by zero (in2 = 0, DIV or DIVU) SHALL use the same latency, set lo = all ones and hi = in1, and set div_zero = 1 in the done cycle.
REQ-027 div_zero SHALL be 0 for all other results and whenever done is 0.
REQ-028 Operand inputs SHALL be don't-care outside the accepting cycle; results SHALL depend only on the latched copies.

Reset
REQ-029 reset SHALL, at the next rising clk edge, force state IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0 and counter = 0.
REQ-030 reset SHALL take priority over start.
REQ-031 reset during CALC or FINISH SHALL abort the operation with no result written and no done.

Verification (WIDTH=32 unless noted)
REQ-032 The bench SHALL cover MULTU in1=ffffffff, in2=0000000f -> busy for 33 cycles, then done=1 with hi=0000000e, lo=fffffff1, div_zero=0.
REQ-033 The bench SHALL cover MULT ffffffff x 00000002 -> hi=ffffffff, lo=fffffffe; followed by DIV fffffff9 / 00000002 -> lo=fffffffd, hi=ffffffff.
REQ-034 The bench SHALL cover DIVU 00000005 / 00000000 -> lo=ffffffff, hi=00000005, div_zero=1 with done; then DIV 80000000 / ffffffff -> lo=80000000, hi=00000000, div_zero=0.
REQ-035 The bench SHALL cover MTHI 12345678, then MTLO 9abcdef0 on the next cycle -> hi=12345678 and lo=9abcdef0 after one edge each, busy=0 and done=0 throughout.
REQ-036 The bench SHALL cover MTLO 0000aaaa with start pulsed during a MULTU -> request ignored, lo = product; then reset 5 cycles into a DIVU -> busy=0, hi=lo=0 next edge, no done.
REQ-037 The bench SHALL cover WIDTH=8 MULT 80 x 80 -> busy for 9 cycles, hi=40, lo=00.
